// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, instruction fetch handshake and retire counter
module pc_fetch_unit #(
    parameter int          WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             JB_instr_i,
    input  logic             JALR_instr_i,
    input  logic [WIDTH-1:0] imm_ext_i,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             stall_i,
    input  logic             imem_ready_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic [WIDTH-1:0] instr_o,
    output logic             instr_valid_o,
    output logic             misaligned_o,
    output logic [WIDTH-1:0] instr_count_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] FOUR     = WIDTH'(4);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] LSB_MASK = ~ONE;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             mis_q, mis_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] next_pc;

    assign pc_plus4 = pc_q + FOUR;

    // JALR without a taken jump/branch falls through as sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (JB_instr_i) begin
            if (JALR_instr_i) begin
                next_pc = alu_result_i & LSB_MASK;
            end else begin
                next_pc = pc_q + imm_ext_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        case (state_q)
            BOOT: begin
                valid_d = 1'b0;
                state_d = FETCH;
            end
            FETCH: begin
                valid_d = 1'b0;
                if (imem_ready_i) begin
                    instr_d = imem_rdata_i;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (!stall_i) begin
                    cnt_d   = cnt_q + ONE;
                    valid_d = 1'b0;
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end else begin
                        // PC keeps pointing at the faulting instruction.
                        mis_d   = 1'b1;
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req_o    = (state_q == FETCH);
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign misaligned_o  = mis_q;
    assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed vector bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        jb, jalr, stall, ready;
    logic [31:0] imm, alu, rdata;
    logic        req, valid, mis;
    logic [31:0] addr, pc, pc4, instr, cnt;

    logic       rst8;
    logic       req8, valid8, mis8;
    logic [7:0] addr8, pc8, pc48, instr8, cnt8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_i(rst),
        .JB_instr_i(jb), .JALR_instr_i(jalr),
        .imm_ext_i(imm), .alu_result_i(alu),
        .stall_i(stall), .imem_ready_i(ready), .imem_rdata_i(rdata),
        .imem_req_o(req), .imem_addr_o(addr), .pc_o(pc), .pc_plus4_o(pc4),
        .instr_o(instr), .instr_valid_o(valid), .misaligned_o(mis),
        .instr_count_o(cnt)
    );

    // Narrow instance so the retire counter wrap is reachable quickly.
    pc_fetch_unit #(.WIDTH(8), .RESET_PC(8'h00)) dut8 (
        .clk_i(clk), .rst_i(rst8),
        .JB_instr_i(1'b0), .JALR_instr_i(1'b0),
        .imm_ext_i(8'h00), .alu_result_i(8'h00),
        .stall_i(1'b0), .imem_ready_i(1'b1), .imem_rdata_i(8'h13),
        .imem_req_o(req8), .imem_addr_o(addr8), .pc_o(pc8), .pc_plus4_o(pc48),
        .instr_o(instr8), .instr_valid_o(valid8), .misaligned_o(mis8),
        .instr_count_o(cnt8)
    );

    typedef struct {
        logic        stall, jb, jalr, ready;
        logic [31:0] imm, alu, rdata;
        logic [31:0] e_pc, e_instr, e_cnt;
        logic        e_valid, e_req, e_mis;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic s, input logic j, input logic jr, input logic rd,
                                input logic [31:0] im, input logic [31:0] al, input logic [31:0] da,
                                input logic [31:0] epc, input logic [31:0] ein, input logic [31:0] ecn,
                                input logic ev, input logic erq, input logic ems);
        vec_t v;
        v.stall = s; v.jb = j; v.jalr = jr; v.ready = rd;
        v.imm = im; v.alu = al; v.rdata = da;
        v.e_pc = epc; v.e_instr = ein; v.e_cnt = ecn;
        v.e_valid = ev; v.e_req = erq; v.e_mis = ems;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string nm, input logic [31:0] epc, input logic [31:0] ein,
                             input logic [31:0] ecn, input logic ev, input logic erq, input logic ems);
        chk({nm, " pc"}, pc, epc);
        chk({nm, " addr"}, addr, epc);
        chk({nm, " pc4"}, pc4, epc + 32'd4);
        chk({nm, " instr"}, instr, ein);
        chk({nm, " cnt"}, cnt, ecn);
        chk({nm, " valid"}, {31'd0, valid}, {31'd0, ev});
        chk({nm, " req"}, {31'd0, req}, {31'd0, erq});
        chk({nm, " mis"}, {31'd0, mis}, {31'd0, ems});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            stl jb jr rdy imm            alu            rdata          pc     instr          cnt v r m
        vecs[0]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h00, 32'h0,         0,  0,0,0);
        vecs[1]  = mk(0, 1, 0, 1, 32'h100,       32'h0,         32'hA000_0000, 32'h00, 32'h0,         0,  0,1,0);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h00, 32'hA000_0000, 0,  1,0,0);
        vecs[3]  = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'hA000_0001, 32'h04, 32'hA000_0000, 1,  0,1,0);
        vecs[4]  = mk(0, 0, 1, 0, 32'h0,         32'h0,         32'h0,         32'h04, 32'hA000_0001, 1,  1,0,0);
        vecs[5]  = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'hA000_0002, 32'h08, 32'hA000_0001, 2,  0,1,0);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h08, 32'hA000_0002, 2,  1,0,0);
        vecs[7]  = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'hA000_0003, 32'h0C, 32'hA000_0002, 3,  0,1,0);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0C, 32'hA000_0003, 3,  1,0,0);
        vecs[9]  = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'hA000_0004, 32'h10, 32'hA000_0003, 4,  0,1,0);
        vecs[10] = mk(0, 1, 0, 0, 32'hFFFF_FFF8, 32'h0,         32'h0,         32'h10, 32'hA000_0004, 4,  1,0,0);
        vecs[11] = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'hA000_0005, 32'h08, 32'hA000_0004, 5,  0,1,0);
        vecs[12] = mk(0, 1, 1, 0, 32'h0,         32'h0000_0103, 32'h0,         32'h08, 32'hA000_0005, 5,  1,0,0);
        vecs[13] = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'hBEEF_0000, 32'h08, 32'hA000_0005, 6,  0,0,1);
        vecs[14] = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'hBEEF_0001, 32'h08, 32'hA000_0005, 6,  0,0,1);

        rst = 1'b1; rst8 = 1'b1;
        jb = 0; jalr = 0; stall = 0; ready = 0;
        imm = 0; alu = 0; rdata = 0;
        step();
        chk_state("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            stall = vecs[i].stall; jb = vecs[i].jb; jalr = vecs[i].jalr;
            ready = vecs[i].ready; imm = vecs[i].imm; alu = vecs[i].alu;
            rdata = vecs[i].rdata;
            chk_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                      vecs[i].e_cnt, vecs[i].e_valid, vecs[i].e_req, vecs[i].e_mis);
            step();
        end

        // Asynchronous reset out of HALT.
        rst = 1'b1; jb = 0; jalr = 0; ready = 0;
        #1;
        chk_state("rst_halt", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step();
        rst = 1'b0;
        chk_state("boot", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step();

        // Three wait states at PC 0.
        for (int k = 0; k < 3; k++) begin
            ready = 0; rdata = 32'hDEAD_0000 + k;
            chk_state($sformatf("wait%0d", k), 32'h0, 32'h0, 32'h0, 0, 1, 0);
            step();
        end
        ready = 1; rdata = 32'hCAFE_0001;
        chk_state("wait3", 32'h0, 32'h0, 32'h0, 0, 1, 0);
        step();
        ready = 1; rdata = 32'hBAD0_BAD0; stall = 1;
        chk_state("waitdone", 32'h0, 32'hCAFE_0001, 32'h0, 1, 0, 0);

        // Stall in VALID with toggling redirect; memory data must be ignored.
        for (int k = 0; k < 5; k++) begin
            step();
            jb = k[0]; imm = 32'h40;
            chk_state($sformatf("stall%0d", k), 32'h0, 32'hCAFE_0001, 32'h0, 1, 0, 0);
        end
        stall = 0; jb = 1; jalr = 0; imm = 32'h20; ready = 0;
        step();
        chk_state("redir", 32'h20, 32'hCAFE_0001, 32'h1, 0, 1, 0);
        jb = 0; ready = 1; rdata = 32'h0000_1234;
        step();
        chk_state("fetch20", 32'h20, 32'h0000_1234, 32'h1, 1, 0, 0);
        jb = 1; jalr = 0; imm = 32'h6;
        step();
        for (int k = 0; k < 3; k++) begin
            chk_state($sformatf("halt%0d", k), 32'h20, 32'h0000_1234, 32'h2, 0, 0, 1);
            step();
        end

        rst = 1'b1; jb = 0; ready = 0;
        #1;
        chk_state("rst2", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        ready = 1; rdata = 32'h0000_0055;
        chk_state("fetch0", 32'h0, 32'h0, 32'h0, 0, 1, 0);

        // Reset during FETCH with a response pending.
        #1 rst = 1'b1;
        #1;
        chk_state("rst_fetch", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step();
        rst = 1'b0;
        chk_state("boot2", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step();
        chk_state("fetch1", 32'h0, 32'h0, 32'h0, 0, 1, 0);
        step();
        chk_state("cap55", 32'h0, 32'h0000_0055, 32'h0, 1, 0, 0);

        // Counter wrap on the 8-bit instance: count k after 1+2k edges.
        rst8 = 1'b0;
        repeat (511) @(posedge clk);
        #1;
        chk("wrap 255", {24'd0, cnt8}, 32'd255);
        repeat (2) @(posedge clk);
        #1;
        chk("wrap 0", {24'd0, cnt8}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("wrap 1", {24'd0, cnt8}, 32'd1);
        chk("wrap mis", {31'd0, mis8}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
